// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline W-stage writes win; long-latency results queue and drain in idle cycles.
// Latency: wb -> grf_we 1 cycle; lu accepted into empty FIFO -> grf_we 2 cycles.
// Backpressure: lu_ready = !full, from state only; a full FIFO refuses even in a draining cycle.
// Optional trace: define GRF_WB_TRACE_EN to print every retired GRF write.
module grf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_we,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic [31:0]              wb_pc,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_addr,
  input  logic [31:0]              lu_data,
  input  logic [31:0]              lu_pc,
  output logic                     grf_we,
  output logic [4:0]               grf_a3,
  output logic [31:0]              grf_data,
  output logic [31:0]              grf_pc,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage; live is cleared when an entry is killed or popped, so
  // unoccupied slots never contribute to the pending vector.
  logic [4:0]       fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [31:0]      fifo_pc_q   [DEPTH];
  logic [DEPTH-1:0] fifo_live_q, fifo_live_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  logic             grf_we_q, grf_we_d;
  logic [4:0]       grf_a3_q, grf_a3_d;
  logic [31:0]      grf_data_q, grf_data_d;
  logic [31:0]      grf_pc_q, grf_pc_d;
  logic [31:0]      pending_d;

  logic full, wb_act, push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign lu_ready = !full;
  assign wb_act   = wb_we && (wb_addr != 5'd0);
  // $0 results complete the handshake but are never stored.
  assign push     = lu_valid && lu_ready && (lu_addr != 5'd0);
  assign pop      = !wb_act && (count_q != '0);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // Live-bit update: a wb write kills older same-address entries; the slot being
  // pushed this cycle is written after the kill so it stays live.
  always_comb begin
    fifo_live_d = fifo_live_q;
    if (wb_act) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_addr_q[i] == wb_addr) fifo_live_d[i] = 1'b0;
      end
    end
    if (pop)  fifo_live_d[rd_ptr_q] = 1'b0;
    if (push) fifo_live_d[wr_ptr_q] = 1'b1;
  end

  // Output selection: pipeline write first, then FIFO head; a killed head burns the cycle with we=0.
  always_comb begin
    grf_we_d   = 1'b0;
    grf_a3_d   = grf_a3_q;
    grf_data_d = grf_data_q;
    grf_pc_d   = grf_pc_q;
    if (wb_act) begin
      grf_we_d   = 1'b1;
      grf_a3_d   = wb_addr;
      grf_data_d = wb_data;
      grf_pc_d   = wb_pc;
    end else if (pop) begin
      grf_we_d   = fifo_live_q[rd_ptr_q];
      grf_a3_d   = fifo_addr_q[rd_ptr_q];
      grf_data_d = fifo_data_q[rd_ptr_q];
      grf_pc_d   = fifo_pc_q[rd_ptr_q];
    end
  end

  // FIFO pointers, occupancy and entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      fifo_live_q <= fifo_live_d;
      count_q     <= count_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= lu_addr;
        fifo_data_q[wr_ptr_q] <= lu_data;
        fifo_pc_q[wr_ptr_q]   <= lu_pc;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Registered GRF write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grf_we_q   <= 1'b0;
      grf_a3_q   <= '0;
      grf_data_q <= '0;
      grf_pc_q   <= '0;
    end else begin
      grf_we_q   <= grf_we_d;
      grf_a3_q   <= grf_a3_d;
      grf_data_q <= grf_data_d;
      grf_pc_q   <= grf_pc_d;
    end
  end

  // Pending registers: live queued writes plus the write sitting in the output register.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_live_q[i]) pending_d[fifo_addr_q[i]] = 1'b1;
    end
    if (grf_we_q) pending_d[grf_a3_q] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign grf_we     = grf_we_q;
  assign grf_a3     = grf_a3_q;
  assign grf_data   = grf_data_q;
  assign grf_pc     = grf_pc_q;
  assign pending    = pending_d;
  assign fifo_count = count_q;

`ifdef GRF_WB_TRACE_EN
  // Trace of every retired GRF write.
  always @(posedge clk) begin
    if (!reset && grf_we_q) $display("@%h: $%d <= %h", grf_pc_q, grf_a3_q, grf_data_q);
  end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_grf_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, wb_pc;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data, lu_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_data, grf_pc, pending;
  logic [2:0]  fifo_count;

  grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data), .lu_pc(lu_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_data(grf_data), .grf_pc(grf_pc),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        live;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of outstanding results plus the expected output register.
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_data, m_pc;
  logic        last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    foreach (q[i]) if (q[i].live) p[q[i].addr] = 1'b1;
    if (m_we) p[m_a3] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic check_all();
    check("grf_we",     {31'd0, grf_we},     {31'd0, m_we});
    check("grf_a3",     {27'd0, grf_a3},     {27'd0, m_a3});
    check("grf_data",   grf_data,            m_data);
    check("grf_pc",     grf_pc,              m_pc);
    check("fifo_count", {29'd0, fifo_count}, 32'(q.size()));
    check("lu_ready",   {31'd0, lu_ready},   {31'd0, (q.size() < DEPTH)});
    check("pending",    pending,             m_pending());
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_a3 = '0; m_data = '0; m_pc = '0;
  endtask

  // Apply one cycle of inputs (called at a falling edge), advance the model, check at the next falling edge.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] wp,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld, input logic [31:0] lp);
    logic ready, wbact;
    ent_t e;
    wb_we = we; wb_addr = wa; wb_data = wd; wb_pc = wp;
    lu_valid = lv; lu_addr = la; lu_data = ld; lu_pc = lp;
    ready    = (q.size() < DEPTH);
    wbact    = we && (wa != 5'd0);
    last_acc = lv && ready;
    if (wbact) foreach (q[i]) if (q[i].addr == wa) q[i].live = 1'b0;
    if (wbact) begin
      m_we = 1'b1; m_a3 = wa; m_data = wd; m_pc = wp;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = e.live; m_a3 = e.addr; m_data = e.data; m_pc = e.pc;
    end else begin
      m_we = 1'b0;
    end
    if (last_acc && la != 5'd0) begin
      e.addr = la; e.data = ld; e.pc = lp; e.live = 1'b1;
      q.push_back(e);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ov;
    logic [4:0]  oa;
    logic [31:0] od, op;
    logic        heavy, we;

    reset = 1'b1;
    wb_we = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0; lu_pc = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Simple pipeline write.
    cyc(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0);
    check("wb_we",      {31'd0, grf_we}, 32'd1);
    check("wb_a3",      {27'd0, grf_a3}, 32'd5);
    check("wb_data",    grf_data, 32'h1234);
    check("wb_pc",      grf_pc,   32'h3000);
    check("wb_pending5", {31'd0, pending[5]}, 32'd1);
    idle();
    check("wb_pending5_clear", {31'd0, pending[5]}, 32'd0);

    // Priority: queued lu result waits behind three pipeline writes.
    cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd8, 32'hAA, 32'h4000);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 5'd9, 32'h900 + 32'(k), 32'h5000, 1'b0, 5'd0, 32'd0, 32'd0);
      check("prio_wb_a3", {27'd0, grf_a3}, 32'd9);
      check("prio_pend8", {31'd0, pending[8]}, 32'd1);
    end
    idle();
    check("prio_lu_we",   {31'd0, grf_we}, 32'd1);
    check("prio_lu_a3",   {27'd0, grf_a3}, 32'd8);
    check("prio_lu_data", grf_data, 32'hAA);
    idle();

    // Kill: a later wb write to the same register turns the queued result into a bubble.
    cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd4, 32'h11, 32'h6000);
    cyc(1'b1, 5'd4, 32'h22, 32'h6004, 1'b0, 5'd0, 32'd0, 32'd0);
    check("kill_wb_data", grf_data, 32'h22);
    idle();
    check("kill_pop_we",  {31'd0, grf_we}, 32'd0);
    check("kill_pend4",   {31'd0, pending[4]}, 32'd0);
    check("kill_count",   {29'd0, fifo_count}, 32'd0);

    // Full: four results queue while the pipeline writes, then drain in order.
    for (int k = 1; k <= 4; k++)
      cyc(1'b1, 5'd9, 32'd0, 32'd0, 1'b1, 5'(k), 32'h100 + 32'(k), 32'h7000);
    check("full_count", {29'd0, fifo_count}, 32'd4);
    check("full_ready", {31'd0, lu_ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check("drain_a3",   {27'd0, grf_a3}, 32'(k));
      check("drain_data", grf_data, 32'h100 + 32'(k));
      check("drain_ready", {31'd0, lu_ready}, 32'd1);
    end
    idle();

    // $0 filtering on both sources.
    cyc(1'b1, 5'd0, 32'hDEAD, 32'd0, 1'b1, 5'd0, 32'hBEEF, 32'd0);
    check("zero_acc",   {31'd0, last_acc}, 32'd1);
    check("zero_we",    {31'd0, grf_we}, 32'd0);
    check("zero_count", {29'd0, fifo_count}, 32'd0);
    check("zero_pend0", {31'd0, pending[0]}, 32'd0);

    // Randomized traffic, alternating wb-heavy and wb-light phases to hit full and drain.
    ov = 1'b0; oa = '0; od = '0; op = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ov && $urandom_range(0, 2) != 0) begin
        ov = 1'b1;
        oa = 5'($urandom_range(0, 7));
        od = $urandom;
        op = $urandom;
      end
      heavy = ((n / 50) % 2) == 0;
      we    = $urandom_range(0, 99) < (heavy ? 85 : 20);
      cyc(we, 5'($urandom_range(0, 7)), $urandom, $urandom, ov, oa, od, op);
      if (last_acc) ov = 1'b0;
    end
    repeat (6) idle();

    // Asynchronous reset mid-cycle with three entries queued.
    for (int k = 1; k <= 3; k++)
      cyc(1'b1, 5'd9, 32'd0, 32'd0, 1'b1, 5'(k + 10), 32'h200 + 32'(k), 32'h8000);
    check("rst_pre_count", {29'd0, fifo_count}, 32'd3);
    #2;
    reset = 1'b1;
    wb_we = 0; wb_addr = 0; lu_valid = 0; lu_addr = 0;
    model_reset();
    #1;
    check("rst_we",    {31'd0, grf_we}, 32'd0);
    check("rst_a3",    {27'd0, grf_a3}, 32'd0);
    check("rst_data",  grf_data, 32'd0);
    check("rst_pc",    grf_pc, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, lu_ready}, 32'd1);
    check("rst_pend",  pending, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle();
      check("post_rst_we", {31'd0, grf_we}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-side front end for the general register file: merges the main pipeline's W-stage write with results from long-latency producers (MDU, slow memory) into the GRF's single write port. Long-latency results wait in a small FIFO and drain only in cycles the pipeline does not write. A per-register pending vector goes to the stall unit. Outputs drive GRF `WE`/`A3`/`Data`/`PC` directly.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wb_we` in 1: pipeline write request this cycle.
- `wb_addr` in 5: pipeline destination register.
- `wb_data` in 32: pipeline write data.
- `wb_pc` in 32: PC of the writing instruction.
- `lu_valid` in 1: long-latency result offered.
- `lu_ready` out 1: FIFO can accept; equals !full.
- `lu_addr` in 5, `lu_data` in 32, `lu_pc` in 32: long-latency result fields.
- `grf_we` out 1, `grf_a3` out 5, `grf_data` out 32, `grf_pc` out 32: registered GRF write port.
- `pending` out 32: bit i set while a live write to $i sits in the FIFO or the output register. Bit 0 is always 0.
- `fifo_count` out $clog2(DEPTH)+1: occupied entries, live or killed.

## Operation
- Accept: an lu result is accepted when `lu_valid && lu_ready`.
  - `lu_addr`≠0: enqueue {addr, data, pc, live=1}.
  - `lu_addr`=0: handshake completes, nothing is enqueued.
- Kill: when `wb_we && wb_addr`≠0, every FIFO entry already present with the same address has live cleared.
  - An entry enqueued in the same cycle is not killed; the same-cycle wb write is the older one.
- Output selection, one per cycle, in priority order:
  1. `wb_we && wb_addr`≠0: the output register loads wb fields with we=1.
  2. Otherwise, FIFO non-empty: pop head. The output loads head fields with we = head.live. A killed head consumes the cycle with we=0.
  3. Otherwise: we=0. addr/data/pc hold their previous values.
- `wb_we` with `wb_addr`=0 is treated as no pipeline write, so FIFO drain proceeds.
- Push and pop may occur in the same cycle. `lu_ready` ignores a same-cycle pop, so a full FIFO stalls one cycle even while draining.
- Pointers wrap modulo DEPTH. `fifo_count` = push − pop, in 0..DEPTH.
- `pending` is combinational from state: OR of live FIFO entries by address, OR (`grf_we` ? bit `grf_a3` : 0).

## Timing
- Reset (asynchronous, immediate): `grf_we`=0, `grf_a3`=0, `grf_data`=0, `grf_pc`=0, FIFO empty, `fifo_count`=0, `lu_ready`=1, `pending`=0.
- Reset mid-drain discards all queued entries; no write is issued after reset asserts.
- Latency:
  - wb request → `grf_we`: 1 cycle.
  - lu accepted into empty FIFO with no wb traffic → `grf_we`: 2 cycles (enqueue edge, then pop edge).
- Starvation: continuous wb writes starve the FIFO indefinitely. This is by design; the stall unit uses `pending`.
- `lu_ready` depends only on state, not on `lu_valid`.
- The lu producer must hold `lu_*` stable until accepted.

## Configuration
- `GRF_WB_TRACE_EN`
  - Defined: on each rising edge with `grf_we`=1 and reset low, `$display("@%h: $%d <= %h", grf_pc, grf_a3, grf_data)`.
  - Undefined: no display code is compiled. Functional behaviour is identical.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle with 3 entries queued → outputs zero immediately, `fifo_count`=0, `lu_ready`=1; no `grf_we` after release.
- Simple wb: `wb_we`=1, addr=5, data=0x1234, pc=0x3000 → next edge `grf_we`=1, `grf_a3`=5, `grf_data`=0x1234, `grf_pc`=0x3000; `pending[5]`=1 for that cycle.
- Priority:
  - Setup: lu write ($8, 0xAA) queued; `wb_we`=1 to $9 for 3 cycles.
  - Required: $9 writes for 3 cycles, then $8 ← 0xAA on the 4th.
- Kill:
  - Setup: enqueue lu $4 ← 0x11, then wb $4 ← 0x22.
  - Required: `grf` writes $4 ← 0x22; the popped $4 entry yields `grf_we`=0; `pending[4]`=0 after the wb write retires.
- Full:
  - Setup: DEPTH=4; push 4 lu results while wb writes every cycle.
  - Required: `lu_ready`=0, `fifo_count`=4. Drop wb → entries drain in order over 4 cycles, `lu_ready`=1 after first pop.
- $0 filtering: lu to $0 and wb to $0 → handshake completes, `fifo_count` unchanged, `grf_we` never 1 for $0, `pending[0]`=0.
